// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory fetch arbiter.
package imem_fetch_arbiter_pkg;

  // Fetch slot identity, also the value stored in the ordering FIFO
  typedef enum logic {
    SLOT_INST1 = 1'b0,
    SLOT_INST2 = 1'b1
  } fetch_slot_e;

  // Default number of accepted-but-unanswered requests
  localparam int IMEM_ARB_DEPTH = 4;

endpackage

// File: rtl/imem_arb_tag_fifo.sv
// Ordering FIFO for the fetch arbiter: DEPTH entries of one-bit slot IDs.
// Pointers wrap naturally; full/empty come from a separate occupancy count.
module imem_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];
  // Guard against overflow/underflow even if the caller misbehaves
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, emptied on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one instruction-memory req/gnt port between the two fetch slots
// and steers in-order responses back to the requesting slot.
// Build option: IMEM_ARB_FIXED_PRIO_EN gives Inst1 fixed priority; otherwise
// round-robin between slots.
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = IMEM_ARB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst1_req,
  input  logic [ADDR_W-1:0]      inst1_addr,
  output logic                   inst1_gnt,
  output logic                   inst1_rvalid,
  output logic [DATA_W-1:0]      inst1_rdata,
  input  logic                   inst2_req,
  input  logic [ADDR_W-1:0]      inst2_addr,
  output logic                   inst2_gnt,
  output logic                   inst2_rvalid,
  output logic [DATA_W-1:0]      inst2_rdata,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   rsp_err
);

  fetch_slot_e winner;
  logic        accept, pop;
  logic        fifo_head, fifo_empty, fifo_full;
  logic        rsp_err_q, rsp_err_d;

`ifndef IMEM_ARB_FIXED_PRIO_EN
  fetch_slot_e rr_q, rr_d;

  // Winner: sole requester, otherwise whichever slot the pointer favours
  always_comb begin
    winner = SLOT_INST1;
    if (inst1_req && inst2_req) winner = rr_q;
    else if (inst2_req)         winner = SLOT_INST2;
  end

  // Pointer moves to the losing slot only when a request is accepted
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (winner == SLOT_INST1) ? SLOT_INST2 : SLOT_INST1;
  end

  // Round-robin pointer register, favours Inst1 out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= SLOT_INST1;
    else      rr_q <= rr_d;
  end
`else
  // Winner: Inst1 (older in program order) whenever it requests
  always_comb begin
    winner = SLOT_INST1;
    if (!inst1_req && inst2_req) winner = SLOT_INST2;
  end
`endif

  // Request path; rst gates outputs so nothing is offered while held in reset.
  // Full blocks the request even if a response frees an entry this cycle.
  assign mem_req   = rst && (inst1_req || inst2_req) && !fifo_full;
  assign mem_addr  = (winner == SLOT_INST2) ? inst2_addr : inst1_addr;
  assign accept    = mem_req && mem_gnt;
  assign inst1_gnt = accept && (winner == SLOT_INST1);
  assign inst2_gnt = accept && (winner == SLOT_INST2);

  // Response path: head of the ordering FIFO names the owner of this beat
  assign pop          = rst && mem_rvalid && !fifo_empty;
  assign inst1_rvalid = pop && (fifo_head == 1'b0);
  assign inst2_rvalid = pop && (fifo_head == 1'b1);
  assign inst1_rdata  = mem_rdata;
  assign inst2_rdata  = mem_rdata;

  imem_arb_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (winner == SLOT_INST2),
    .pop     (pop),
    .head_id (fifo_head),
    .count   (outstanding),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Sticky error: a response arrived that no accepted request was waiting for
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (mem_rvalid && fifo_empty) rsp_err_d = 1'b1;
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsp_err_q <= 1'b0;
    else      rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: stimulus pushes expected grants and
// responses into queues; a monitor pops and compares whenever the DUT presents one.
module tb_imem_fetch_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  typedef struct {
    int          slot;
    logic [31:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst1_req, inst2_req;
  logic [AW-1:0] inst1_addr, inst2_addr;
  logic          inst1_gnt, inst2_gnt, inst1_rvalid, inst2_rvalid;
  logic [DW-1:0] inst1_rdata, inst2_rdata;
  logic          mem_req, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [$clog2(D):0] outstanding;
  logic          rsp_err;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t gq[$];
  exp_t rq[$];

  imem_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .inst1_req(inst1_req), .inst1_addr(inst1_addr), .inst1_gnt(inst1_gnt),
    .inst1_rvalid(inst1_rvalid), .inst1_rdata(inst1_rdata),
    .inst2_req(inst2_req), .inst2_addr(inst2_addr), .inst2_gnt(inst2_gnt),
    .inst2_rvalid(inst2_rvalid), .inst2_rdata(inst2_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int s, logic [31:0] v);
    exp_t e;
    e.slot = s;
    e.val  = v;
    return e;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented grant/response must match the head of its queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (inst1_gnt || inst2_gnt) begin
        chk("gnt_onehot", {63'b0, inst1_gnt & inst2_gnt}, 64'd0);
        if (gq.size() == 0) chk("unexpected_gnt", 64'd1, 64'd0);
        else begin
          e = gq.pop_front();
          chk("gnt_slot", inst2_gnt ? 64'd2 : 64'd1, 64'(e.slot));
          chk("gnt_addr", {32'b0, mem_addr}, {32'b0, e.val});
        end
      end
      if (inst1_rvalid || inst2_rvalid) begin
        chk("rvalid_onehot", {63'b0, inst1_rvalid & inst2_rvalid}, 64'd0);
        if (rq.size() == 0) chk("unexpected_rvalid", 64'd1, 64'd0);
        else begin
          e = rq.pop_front();
          chk("rsp_slot", inst2_rvalid ? 64'd2 : 64'd1, 64'(e.slot));
          chk("rsp_data", {32'b0, inst2_rvalid ? inst2_rdata : inst1_rdata}, {32'b0, e.val});
        end
      end
    end
  end

  // Watchdog: the directed sequence is fixed length, this only guards a hang
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b0; inst1_req = 1'b1; inst1_addr = 32'h100;
    inst2_req = 1'b0; inst2_addr = 32'h200;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // Held in reset with a live request
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_gnt", {62'b0, inst1_gnt, inst2_gnt}, 64'd0);
    chk("rst_rvalid", {62'b0, inst1_rvalid, inst2_rvalid}, 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_rsp_err", {63'b0, rsp_err}, 64'd0);

    // Both slots requesting continuously, memory always granting
    next_cyc();
    rst = 1'b1; inst2_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
      gq.push_back(mk(1, 32'h100));
`else
      gq.push_back((i % 2) ? mk(2, 32'h200) : mk(1, 32'h100));
`endif
      @(negedge clk);
      chk("arb_mem_req", {63'b0, mem_req}, 64'd1);
      next_cyc();
    end

    // Full: four accepted, none answered
    inst2_req = 1'b0;
    @(negedge clk);
    chk("full_outstanding", 64'(outstanding), 64'd4);
    chk("full_mem_req", {63'b0, mem_req}, 64'd0);
    next_cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    rq.push_back(mk(1, 32'h11));
    @(negedge clk);
    chk("full_pop_no_refill", {63'b0, mem_req}, 64'd0);
    chk("full_pop_outstanding", 64'(outstanding), 64'd4);
    next_cyc();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    chk("after_pop_mem_req", {63'b0, mem_req}, 64'd1);
    chk("after_pop_outstanding", 64'(outstanding), 64'd3);

    // Drain the rest in grant order
    next_cyc();
    inst1_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
      s = 1;
`else
      s = (k % 2) ? 2 : 1;
`endif
      mem_rvalid = 1'b1; mem_rdata = 32'h11 * (k + 1);
      rq.push_back(mk(s, 32'h11 * (k + 1)));
      @(negedge clk);
      next_cyc();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("drain_outstanding", 64'(outstanding), 64'd0);

    // Inst2 then Inst1, responses routed back in order; overlap push+pop
    next_cyc();
    inst2_req = 1'b1; mem_gnt = 1'b1;
    gq.push_back(mk(2, 32'h200));
    @(negedge clk);
    next_cyc();
    inst2_req = 1'b0; inst1_req = 1'b1; inst1_addr = 32'h104;
    gq.push_back(mk(1, 32'h104));
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA;
    rq.push_back(mk(2, 32'hAAAA));
    @(negedge clk);
    chk("order_out_a", 64'(outstanding), 64'd1);
    next_cyc();
    inst1_req = 1'b0; mem_rdata = 32'hBBBB;
    rq.push_back(mk(1, 32'hBBBB));
    @(negedge clk);
    chk("push_pop_same_cycle", 64'(outstanding), 64'd1);
    next_cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("order_out_end", 64'(outstanding), 64'd0);

    // Stray response with nothing outstanding
    next_cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    @(negedge clk);
    chk("stray_err_not_yet", {63'b0, rsp_err}, 64'd0);
    next_cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_err_set", {63'b0, rsp_err}, 64'd1);
    repeat (3) next_cyc();
    @(negedge clk);
    chk("stray_err_sticky", {63'b0, rsp_err}, 64'd1);

    // Reset clears the error and restores Inst1 priority
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_rsp_err", {63'b0, rsp_err}, 64'd0);
    next_cyc();
    rst = 1'b1; inst1_req = 1'b1; inst2_req = 1'b1;
    inst1_addr = 32'h300; inst2_addr = 32'h400;
    gq.push_back(mk(1, 32'h300));
    @(negedge clk);
    chk("rst2_mem_addr", {32'b0, mem_addr}, 64'h300);

    // Reset with one request outstanding; its late response is an error
    next_cyc();
    inst1_req = 1'b0; inst2_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst3_outstanding", 64'(outstanding), 64'd0);
    chk("rst3_mem_req", {63'b0, mem_req}, 64'd0);
    next_cyc();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    @(negedge clk);
    chk("late_rsp_err_not_yet", {63'b0, rsp_err}, 64'd0);
    next_cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rsp_err", {63'b0, rsp_err}, 64'd1);
    chk("late_rsp_outstanding", 64'(outstanding), 64'd0);

    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
